expr_sig_collector: RTL and testbench
=====================================

EXPR_SIG_COLLECTOR -- requirements
Module: expr_sig_collector

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the sample counter and batch length.
REQ-002 SHALL have parameter SEED, default 32'hFFFFFFFF, meaning the initial signature value.
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, meaning the MISR feedback polynomial.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a batch.
REQ-007 SHALL have port num_samples, input, CNT_W bits: batch length, sampled when start is accepted.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream expression result is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the collector accepts in_y this cycle.
REQ-010 SHALL have port in_y, input, 90 bits: the packed 18-field expression result vector.
REQ-011 SHALL have port expected_sig, input, 32 bits: the golden signature, compared in DONE.
REQ-012 SHALL have port signature, output, 32 bits: the current MISR value.
REQ-013 SHALL have port sample_count, output, CNT_W bits: the number of samples accepted in this batch.
REQ-014 SHALL have port done, output, 1 bit: the batch is complete.
REQ-015 SHALL have port match, output, 1 bit: signature equals expected_sig; valid only while done=1.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE as registered state.
REQ-017 SHALL drive in_ready combinationally as 1 only in RUN; an accept occurs when in_valid and in_ready are both 1.
REQ-018 SHALL, in IDLE or DONE when start=1, load SEED into the signature, clear sample_count, latch num_samples as target, and go to RUN; if num_samples=0 it SHALL go directly to DONE instead.
REQ-019 SHALL ignore start while in RUN, leaving target, count and signature unchanged.
REQ-020 SHALL compute fold = in_y[31:0] ^ in_y[63:32] ^ {6'b0, in_y[89:64]}.
REQ-021 SHALL, on accept, update sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold and increment sample_count, visible the next cycle.
REQ-022 SHALL leave signature and sample_count unchanged on cycles with no accept, including in_valid=1 outside RUN.
REQ-023 SHALL, when an accept makes sample_count+1 equal target, go to DONE on the next cycle; done rises the cycle after the last accept.
REQ-024 SHALL hold done=1 in DONE until start is seen; done=0 in IDLE and RUN.
REQ-025 SHALL compute match as a registered compare of signature against expected_sig, updated every cycle in DONE and forced to 0 outside DONE.
REQ-026 SHALL let sample_count wrap modulo 2^CNT_W; a target equal to 2^CNT_W-1 SHALL still terminate correctly.
REQ-027 SHALL accept no further inputs after the terminating accept within the same batch.

Reset
REQ-028 SHALL, on reset=1 in any state (including mid-RUN), go to IDLE with signature=SEED, sample_count=0, target=0, done=0, match=0 and in_ready=0 on the following cycle.
REQ-029 SHALL give reset priority over start and accept in the same cycle.

Verification
REQ-030 SHALL verify reset: assert reset for 2 cycles -> signature=FFFFFFFF, sample_count=0, done=0, match=0, in_ready=0.
REQ-031 SHALL verify a single sample: start with num_samples=1 and expected_sig=FB3EE249, then one accept of in_y=0 -> next cycle signature=FB3EE249, sample_count=1, done=1; one cycle later match=1.
REQ-032 SHALL verify an empty batch: start with num_samples=0 -> DONE next cycle, signature=FFFFFFFF, sample_count=0, in_ready never 1.
REQ-033 SHALL verify backpressure gaps: num_samples=4 with in_valid toggled 1,0,0,1,1,0,1 -> sample_count increments only on valid cycles; done rises the cycle after the 4th accept; in_ready=0 afterwards.
REQ-034 SHALL verify restart and ignore rules: start pulsed mid-RUN at count 2 of 5 -> no effect, batch ends at 5; start in DONE -> signature reloads to FFFFFFFF, done=0.
REQ-035 SHALL verify reset mid-operation: reset after 3 of 8 accepts -> IDLE, signature=FFFFFFFF, sample_count=0, subsequent in_valid ignored.

Source files
------------

// File: rtl/expr_sig_collector.sv
// Batch signature collector: folds each accepted 90-bit expression result into a
// 32-bit MISR and compares the final signature against a golden value.
module expr_sig_collector #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF,
  parameter logic [31:0] POLY  = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_y,
  input  logic [31:0]      expected_sig,
  output logic [31:0]      signature,
  output logic [CNT_W-1:0] sample_count,
  output logic             done,
  output logic             match
);

  // Handshake: a sample is consumed on a cycle where in_valid and in_ready are both 1;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      fold;
  logic [31:0]      sig_next;
  logic             accept;

  assign in_ready  = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign fold      = in_y[31:0] ^ in_y[63:32] ^ {6'b0, in_y[89:64]};
  assign sig_next  = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
  assign count_inc = sample_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      signature    <= SEED;
      sample_count <= '0;
      target       <= '0;
      done         <= 1'b0;
      match        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature    <= SEED;
            sample_count <= '0;
            target       <= num_samples;
            match        <= 1'b0;
            // A zero-length batch completes immediately with the seed as signature.
            if (num_samples == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              done  <= 1'b0;
            end
          end else begin
            match <= (state == DONE) && (signature == expected_sig);
          end
        end
        RUN: begin
          match <= 1'b0;
          if (accept) begin
            signature    <= sig_next;
            sample_count <= count_inc;
            // Equality (not >=) keeps a target of 2^CNT_W-1 terminating under wrap.
            if (count_inc == target) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          match <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sig_collector.sv
// Directed-plus-random bench for expr_sig_collector with a transaction-level model
// of batch progress, signature accumulation and the done/match flags.
module tb_expr_sig_collector;

  localparam int CNT_W = 6;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [89:0]      in_y;
  logic [31:0]      expected_sig;
  logic [31:0]      signature;
  logic [CNT_W-1:0] sample_count;
  logic             done;
  logic             match;

  int tests = 0;
  int fails = 0;

  // Model of the batch: busy = inputs being collected, finished = batch complete.
  bit               m_busy, m_fin, m_match;
  logic [31:0]      m_sig;
  logic [CNT_W-1:0] m_cnt, m_tgt;

  expr_sig_collector #(.CNT_W(CNT_W), .SEED(SEED), .POLY(POLY)) dut (
    .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .expected_sig(expected_sig), .signature(signature),
    .sample_count(sample_count), .done(done), .match(match)
  );

  always #5 clk = ~clk;

  // Multiply the signature by x modulo POLY, then add the folded sample.
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] y);
    logic [32:0] t;
    logic [31:0] f;
    t = {s, 1'b0};
    if (t[32]) t[31:0] = t[31:0] ^ POLY;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return t[31:0] ^ f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_fin = 0; m_match = 0;
      m_sig = SEED; m_cnt = '0; m_tgt = '0;
    end else if (m_busy) begin
      m_match = 0;
      if (in_valid) begin
        m_sig = misr(m_sig, in_y);
        m_cnt = m_cnt + 1'b1;
        if (m_cnt == m_tgt) begin m_busy = 0; m_fin = 1; end
      end
    end else begin
      m_match = m_fin && (m_sig == expected_sig);
      if (start) begin
        m_match = 0;
        m_sig = SEED; m_cnt = '0; m_tgt = num_samples;
        m_fin  = (num_samples == '0);
        m_busy = (num_samples != '0);
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("signature", signature, m_sig);
    chk("sample_count", 32'(sample_count), 32'(m_cnt));
    chk("done", 32'(done), 32'(m_fin));
    chk("match", 32'(match), 32'(m_match));
    chk("in_ready", 32'(in_ready), 32'(m_busy));
    start = 0;
  endtask

  task automatic rand_y();
    in_y = {26'($urandom), $urandom, $urandom};
  endtask

  task automatic begin_batch(input int n);
    start = 1; num_samples = CNT_W'(n); in_valid = 0;
    cycle();
  endtask

  task automatic accept_n(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; rand_y(); cycle();
    end
    in_valid = 0;
  endtask

  initial begin
    reset = 1; start = 0; num_samples = '0; in_valid = 0; in_y = '0;
    expected_sig = 32'h0;
    m_busy = 0; m_fin = 0; m_match = 0; m_sig = SEED; m_cnt = '0; m_tgt = '0;
    cycle(); cycle();
    chk("reset_sig", signature, 32'hFFFFFFFF);
    chk("reset_cnt", 32'(sample_count), 32'd0);
    chk("reset_done_match_ready", {29'd0, done, match, in_ready}, 32'd0);
    reset = 0;
    cycle();

    // Single sample of zero.
    expected_sig = 32'hFB3EE249;
    begin_batch(1);
    in_valid = 1; in_y = '0;
    cycle();
    in_valid = 0;
    chk("single_sig", signature, 32'hFB3EE249);
    chk("single_cnt", 32'(sample_count), 32'd1);
    chk("single_done", 32'(done), 32'd1);
    cycle();
    chk("single_match", 32'(match), 32'd1);

    // Empty batch.
    begin_batch(0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_sig", signature, 32'hFFFFFFFF);
    chk("empty_ready", 32'(in_ready), 32'd0);
    in_valid = 1; rand_y(); cycle(); cycle();
    in_valid = 0;
    chk("empty_cnt", 32'(sample_count), 32'd0);

    // Backpressure gaps on a 4-sample batch.
    begin_batch(4);
    begin
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        in_valid = pat[i]; rand_y(); cycle();
      end
    end
    in_valid = 0;
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_cnt", 32'(sample_count), 32'd4);
    in_valid = 1; rand_y(); cycle();
    in_valid = 0;
    chk("gap_ready_after", 32'(in_ready), 32'd0);
    chk("gap_cnt_after", 32'(sample_count), 32'd4);

    // Start ignored mid-run, then restart from DONE.
    begin_batch(5);
    accept_n(2);
    start = 1; num_samples = CNT_W'(9); cycle();
    accept_n(3);
    chk("ignore_cnt", 32'(sample_count), 32'd5);
    chk("ignore_done", 32'(done), 32'd1);
    begin_batch(3);
    chk("restart_sig", signature, 32'hFFFFFFFF);
    chk("restart_done", 32'(done), 32'd0);
    accept_n(3);

    // Reset in the middle of a batch.
    begin_batch(8);
    accept_n(3);
    reset = 1; cycle(); reset = 0;
    chk("midreset_sig", signature, 32'hFFFFFFFF);
    chk("midreset_cnt", 32'(sample_count), 32'd0);
    for (int i = 0; i < 3; i++) begin in_valid = 1; rand_y(); cycle(); end
    in_valid = 0;
    chk("midreset_ignored", 32'(sample_count), 32'd0);

    // Random batches with random gaps; golden value chosen to hit or miss.
    for (int b = 0; b < 12; b++) begin
      int guard;
      begin_batch(int'($urandom_range(1, 10)));
      guard = 0;
      while (m_busy && guard < 200) begin
        in_valid = $urandom_range(0, 1) == 1; rand_y(); cycle(); guard++;
      end
      in_valid = 0;
      chk("rand_finished", 32'(m_busy), 32'd0);
      expected_sig = ($urandom_range(0, 1) == 1) ? m_sig : m_sig ^ 32'h1;
      cycle(); cycle();
    end

    // Largest representable target.
    begin_batch((1 << CNT_W) - 1);
    accept_n((1 << CNT_W) - 1);
    chk("max_done", 32'(done), 32'd1);
    chk("max_cnt", 32'(sample_count), 32'((1 << CNT_W) - 1));
    accept_n(2);
    chk("max_cnt_after", 32'(sample_count), 32'((1 << CNT_W) - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
